// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector: run-time pattern/length/overlap, valid-qualified
// input, registered Moore detection pulse and saturating detection counter.
module seq_det_prog #(
  parameter int                 PAT_W   = 8,
  parameter int                 LEN_W   = 4,
  parameter int                 CNT_W   = 8,
  parameter logic [PAT_W-1:0]   RST_PAT = 8'b0000_1010,
  parameter logic [LEN_W-1:0]   RST_LEN = 4'd4,
  parameter logic               RST_OVL = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In,
  input  logic             In_Vld,
  input  logic             Cfg_Ld,
  input  logic [PAT_W-1:0] Pattern,
  input  logic [LEN_W-1:0] Pat_Len,
  input  logic             Overlap,
  input  logic             Cnt_Clr,
  output logic             OP,
  output logic [CNT_W-1:0] Det_Cnt,
  output logic [1:0]       CS,
  output logic [LEN_W-1:0] Len_Act
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ARMED = 2'd1,
    S_HIT   = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic             op_q, op_d;
  state_e           cs_q, cs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] hist_new_s;
  logic [PAT_W-1:0] mask_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic [LEN_W-1:0] len_clamp_s;
  logic             match_s;

  // Candidate history/fill for this sample and the length-masked pattern compare
  always_comb begin
    hist_new_s = {hist_q[PAT_W-2:0], In};
    if (fill_q >= LEN_MAX) begin
      fill_inc_s = LEN_MAX;
    end else begin
      fill_inc_s = fill_q + LEN_ONE;
    end
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (i < int'(len_q));
    end
    match_s = In_Vld && !Cfg_Ld && (fill_inc_s >= len_q) &&
              (((hist_new_s ^ pat_q) & mask_s) == {PAT_W{1'b0}});
  end

  // Clamp the requested length into 1..PAT_W
  always_comb begin
    if (Pat_Len == {LEN_W{1'b0}}) begin
      len_clamp_s = LEN_ONE;
    end else if (Pat_Len > LEN_MAX) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = Pat_Len;
    end
  end

  // Next-state logic: config load beats sampling; idle cycles only retire a HIT
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    op_d   = 1'b0;
    cs_d   = cs_q;
    if (Cfg_Ld) begin
      pat_d  = Pattern;
      len_d  = len_clamp_s;
      ovl_d  = Overlap;
      hist_d = {PAT_W{1'b0}};
      fill_d = {LEN_W{1'b0}};
      cs_d   = S_FILL;
    end else if (In_Vld) begin
      hist_d = hist_new_s;
      // Non-overlap restarts the count so the next hit needs len fresh bits
      if (match_s && !ovl_q) begin
        fill_d = {LEN_W{1'b0}};
      end else begin
        fill_d = fill_inc_s;
      end
      op_d = match_s;
      case (cs_q)
        S_FILL: begin
          if (match_s) begin
            cs_d = S_HIT;
          end else if (fill_inc_s >= len_q) begin
            cs_d = S_ARMED;
          end else begin
            cs_d = S_FILL;
          end
        end
        S_ARMED: cs_d = match_s ? S_HIT : S_ARMED;
        S_HIT: begin
          if (match_s) begin
            cs_d = S_HIT;
          end else begin
            cs_d = ovl_q ? S_ARMED : S_FILL;
          end
        end
        default: cs_d = S_FILL;
      endcase
    end else begin
      case (cs_q)
        S_FILL:  cs_d = S_FILL;
        S_ARMED: cs_d = S_ARMED;
        S_HIT:   cs_d = ovl_q ? S_ARMED : S_FILL;
        default: cs_d = S_FILL;
      endcase
    end
  end

  // Detection counter: clear beats a same-cycle increment
  always_comb begin
    if (Cnt_Clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (match_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset to the legacy configuration
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hist_q <= {PAT_W{1'b0}};
      fill_q <= {LEN_W{1'b0}};
      pat_q  <= RST_PAT;
      len_q  <= RST_LEN;
      ovl_q  <= RST_OVL;
      op_q   <= 1'b0;
      cs_q   <= S_FILL;
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      op_q   <= op_d;
      cs_q   <= cs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign OP      = op_q;
  assign Det_Cnt = cnt_q;
  assign CS      = cs_q;
  assign Len_Act = len_q;

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
Programmable serial sequence detector: the parametrised successor to the fixed 1010 Moore detectors.
- Pattern value, pattern length (1..PAT_W) and overlap/non-overlap mode are loaded at run time.
- Input bits are qualified by a valid strobe.
- Output is a registered Moore pulse, plus a saturating detection counter.
- Sits between a serial bit source and status/interrupt logic.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of Pat_Len; must hold PAT_W
CNT_W, 8, width of detection counter
RST_PAT, 8'b0000_1010, pattern loaded at reset (low PAT_W bits)
RST_LEN, 4, pattern length loaded at reset
RST_OVL, 0, overlap mode loaded at reset

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  synchronous reset, active-high
In  in  1  serial data bit
In_Vld  in  1  In is sampled only when high
Cfg_Ld  in  1  load Pattern/Pat_Len/Overlap this cycle
Pattern  in  PAT_W  pattern; Pattern[len-1] is the first bit received, Pattern[0] the last
Pat_Len  in  LEN_W  active pattern length
Overlap  in  1  1 = overlapping detection, 0 = non-overlapping
Cnt_Clr  in  1  clear Det_Cnt
OP  out  1  detection pulse (Moore, registered)
Det_Cnt  out  CNT_W  saturating count of detections
CS  out  2  current FSM state (debug)
Len_Act  out  LEN_W  active (clamped) pattern length

Behaviour:
- Rst=1 at an edge:
  - history=0, fill=0, OP=0, Det_Cnt=0, CS=S_FILL.
  - Active config is RST_PAT/RST_LEN/RST_OVL, i.e. legacy 1010 non-overlap.
- Cfg_Ld=1, not in reset:
  - Latch Pattern, Overlap and clamped length: Pat_Len=0 -> 1; Pat_Len>PAT_W -> PAT_W.
  - Clear history, fill and OP; CS=S_FILL. Det_Cnt is kept.
  - Cfg_Ld has priority over In_Vld: the same-cycle bit is discarded.
- Bit sampling, when In_Vld=1 and Cfg_Ld=0:
  - history <= {history[PAT_W-2:0], In}.
  - fill <= min(fill+1, PAT_W).
- Match condition, evaluated on the updated values:
  - fill_new >= len, and
  - history_new[len-1:0] == Pattern[len-1:0].
- On a match:
  - OP <= 1.
  - Det_Cnt increments, saturating at all-ones.
  - Overlap=0: fill <= 0, so the next match needs len fresh bits.
  - Overlap=1: fill is kept, so a suffix of the matched bits can start the next match.
- OP timing:
  - OP is high for exactly one cycle after the edge that sampled the completing bit.
  - It is cleared at the next edge unless that edge produces another match.
  - Cycles with In_Vld=0 clear OP and leave history/fill unchanged.
- FSM (CS encoding):
  - S_FILL=0: fill<len.
  - S_ARMED=1: fill>=len, no match on the last sample.
  - S_HIT=2: match on the last sample; OP = (CS==S_HIT).
  - Transitions:
    - FILL -> HIT on match, else FILL -> ARMED when fill reaches len.
    - ARMED -> HIT on match.
    - HIT -> HIT on back-to-back match.
    - HIT -> FILL if Overlap=0 and no match.
    - HIT -> ARMED if Overlap=1 and no match.
    - Any state -> FILL on Cfg_Ld or Rst.
    - In_Vld=0: HIT -> ARMED (Overlap=1) or FILL (Overlap=0); other states hold.
  - Encoding 3 is illegal -> S_FILL next cycle.
- Cnt_Clr=1: Det_Cnt <= 0. This wins over a same-cycle increment (result 0); OP is unaffected.
- Len_Act reflects the clamped active length and updates the cycle after Cfg_Ld.
- Worst-case latency: input bit to OP = 1 clock.

Test Plan:
- Reset, defaults, stream 1,0,1,0,1,0,1,0 (In_Vld=1) -> OP high after bits 4 and 8 only; Det_Cnt=2; CS after bit 4 = 2, after bit 5 = 0.
- Cfg_Ld Pattern=8'h0A, Pat_Len=4, Overlap=1; same stream -> OP after bits 4, 6, 8; Det_Cnt=3; bits 7-8 produce HIT/ARMED/HIT sequence.
- Overlap=1, Pattern=8'h01, Pat_Len=1; stream 1,1,0,1 -> OP pulses after bits 1, 2, 4, with a back-to-back HIT on bits 1-2; Det_Cnt=3.
- Pat_Len=12 loaded with PAT_W=8, then Pat_Len=0 -> Len_Act=8, then Len_Act=1. Mid-pattern Cfg_Ld after 1,0,1 then 0 -> no OP; history cleared.
- In_Vld gaps: send 1,0,(Vld=0 x3),1,0 -> single OP one cycle after the last bit. Rst asserted after 1,0,1 then 0 -> no OP; Det_Cnt=0.
- CNT_W=2: drive 5 matches -> Det_Cnt saturates at 3. Cnt_Clr on a match cycle -> Det_Cnt=0, OP=1.
